// File: rtl/writeback_queue.sv
// writeback_queue
//   In-order writeback FIFO that merges ALU and load results into one
//   register-file write port. ALU results have fixed priority over loads.
//   Results aimed at register 0 complete their handshake and are dropped.
//   The head entry is popped into a registered output stage every cycle
//   the queue is non-empty, so each entry drives reg_write for one cycle.
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   alu_valid    ALU result offered
//   alu_index    ALU destination register
//   alu_data     ALU result data
//   alu_ready    queue can accept an ALU result
//   mem_valid    load result offered
//   mem_index    load destination register
//   mem_data     load result data
//   mem_ready    queue can accept a load result (not while ALU offers)
//   reg_write    register file write strobe
//   write_index  register file write index
//   write_data   register file write data
//   pending      one bit per register with a write still in flight
//   count        queued entries, excluding the output stage
module writeback_queue #(
  parameter int WIDTH    = 16,
  parameter int REG_BITS = 4,
  parameter int DEPTH    = 4,
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int PW      = $clog2(DEPTH),
  localparam int NREG    = 1 << REG_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_valid,
  input  logic [REG_BITS-1:0] alu_index,
  input  logic [WIDTH-1:0]    alu_data,
  output logic                alu_ready,
  input  logic                mem_valid,
  input  logic [REG_BITS-1:0] mem_index,
  input  logic [WIDTH-1:0]    mem_data,
  output logic                mem_ready,
  output logic                reg_write,
  output logic [REG_BITS-1:0] write_index,
  output logic [WIDTH-1:0]    write_data,
  output logic [NREG-1:0]     pending,
  output logic [CW-1:0]       count
);

  typedef struct packed {
    logic [REG_BITS-1:0] idx;
    logic [WIDTH-1:0]    data;
  } entry_t;

  entry_t              mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic                reg_write_q;
  logic [REG_BITS-1:0] write_index_q;
  logic [WIDTH-1:0]    write_data_q;

  logic                not_full, alu_acc, mem_acc, push, pop;
  entry_t              in_ent;

  // Ready is held low during reset so no source sees a handshake then.
  assign not_full  = count_q < CW'(DEPTH);
  assign alu_ready = reset & not_full;
  assign mem_ready = reset & not_full & ~alu_valid;

  assign alu_acc   = alu_valid & alu_ready;
  assign mem_acc   = mem_valid & mem_ready;
  assign in_ent    = alu_acc ? '{idx: alu_index, data: alu_data}
                             : '{idx: mem_index, data: mem_data};

  // Register-0 writes handshake but never occupy a slot.
  assign push    = (alu_acc | mem_acc) & (in_ent.idx != '0);
  // Pop decision uses the pre-edge count, so a same-edge push is not popped.
  assign pop     = count_q != '0;
  assign count_d = count_q + CW'(push) - CW'(pop);

  // Storage needs no reset: slots are only read while count marks them valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_ent;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      reg_write_q   <= 1'b0;
      write_index_q <= '0;
      write_data_q  <= '0;
    end else begin
      count_q     <= count_d;
      reg_write_q <= pop;
      // DEPTH is a power of two, so pointer wrap is the natural overflow.
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_q      <= rd_ptr_q + PW'(1);
        write_index_q <= mem_q[rd_ptr_q].idx;
        write_data_q  <= mem_q[rd_ptr_q].data;
      end
    end
  end

  // Slot distance from the read pointer; a slot is live when it is closer
  // than count.
  logic [DEPTH-1:0][PW-1:0] slot_off;
  for (genvar g = 0; g < DEPTH; g++) begin : g_off
    assign slot_off[g] = PW'(g) - rd_ptr_q;
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(slot_off[i]) < count_q) pending[mem_q[i].idx] = 1'b1;
    end
    if (reg_write_q) pending[write_index_q] = 1'b1;
    pending[0] = 1'b0;
  end

  assign reg_write   = reg_write_q;
  assign write_index = write_index_q;
  assign write_data  = write_data_q;
  assign count       = count_q;

endmodule
